c3aibadapt_hip_async_capture: RTL and testbench
===============================================

Name: c3aibadapt_hip_async_capture

Overview:
- Transmit-side counterpart of the HIP async update path; sits in the RX channel on the HIP-to-fabric direction.
- Synchronizes HIP async status bits (fast SR 4 bits, slow SR 40 bits) into the oscillator clock domain and snapshots them.
- Serializes the snapshot onto the async sideband chain, framed by one-cycle fsr/ssr load strobes.
- Every frame carries the FSR bits; every SSR_DIV-th frame also carries the SSR bits.

Parameters:
FSR_WIDTH, 4, fast SR bit count (1..8)
SSR_WIDTH, 40, slow SR bit count (8..64)
SSR_DIV, 4, frames per SSR frame (1..16); 1 = SSR sent in every frame

Ports:
rx_clock_async_tx_osc_clk  in  1  oscillator clock; single clock domain
rx_reset_async_tx_osc_clk_rst_n  in  1  async assert, active-low reset
r_rx_async_sr_enable  in  1  static config; 1 = frames run continuously
hip_aib_async_fsr_out  in  FSR_WIDTH  async HIP fast status
hip_aib_async_ssr_out  in  SSR_WIDTH  async HIP slow status
rx_async_hssi_fabric_fsr_load  out  1  one-cycle strobe marking FSR frame start
rx_async_hssi_fabric_ssr_load  out  1  one-cycle strobe marking SSR segment start
rx_async_sr_data  out  1  serial data, LSB first
rx_async_sr_busy  out  1  high while a frame is in progress (not IDLE)
hip_fsr_parity_checker_out  out  1  snapshot FSR bit 0, for parity checker
hip_ssr_parity_checker_out  out  5  snapshot SSR bits [4:0], for parity checker

Behaviour:
- Reset: all outputs 0, state IDLE, frame counter 0, snapshots 0, synchronizer flops 0.
- Sync: each input bit passes a 2-flop synchronizer (bitwise; inputs are quasi-static levels). Input-to-sync-output latency is 2 clocks.
- FSM states: IDLE, FSR_LOAD, FSR_SHIFT, SSR_LOAD, SSR_SHIFT, GAP.
- IDLE: enable=1 -> FSR_LOAD.
- FSR_LOAD (1 cycle): fsr_load=1; synchronized FSR copied to FSR snapshot; ssr_due = (frame counter == 0); when due, synchronized SSR copied to SSR snapshot in the same cycle.
- FSR_SHIFT: FSR_WIDTH cycles, data = fsr_snap[i], i = 0 upward. Exit to SSR_LOAD if ssr_due, else to GAP.
- SSR_LOAD (1 cycle): ssr_load=1, data=0.
- SSR_SHIFT: SSR_WIDTH cycles, data = ssr_snap[i], LSB first. Exit to GAP.
- GAP (1 cycle): data=0.
  - Frame counter increments, wrapping SSR_DIV-1 -> 0.
  - Next state is FSR_LOAD if enable=1, else IDLE.
- rx_async_sr_data is 0 in IDLE, LOAD and GAP states. Load strobes are never high together and never outside their LOAD state.
- Snapshots hold constant from their LOAD cycle until the next LOAD. Input changes during shifting do not affect the frame in flight.
- Frame length with no parity: FSR-only frame = FSR_WIDTH+2 cycles; SSR frame = FSR_WIDTH+SSR_WIDTH+3 cycles.
- Enable deasserted mid-frame: the current frame completes, including any SSR segment, then the FSM goes to IDLE. The frame counter is retained.
- Re-enable in IDLE: FSR_LOAD on the next cycle; the counter continues from its retained value.
- Reset asserted mid-frame: immediate return to reset values; no partial frame is completed.
- Parity-checker outputs reflect the snapshot registers, not the live inputs.

Optional Feature:
- Macro: C3AIBADAPT_HIP_CAPTURE_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of the shifted segment) is appended after the last FSR bit and after the last SSR bit.
  - Each SHIFT state lasts WIDTH+1 cycles.
  - Frame lengths become FSR_WIDTH+3 (FSR-only) and FSR_WIDTH+SSR_WIDTH+5 (SSR frame).
- Undefined: no parity bits; lengths as stated in Behaviour.

Test Plan:
- Reset then enable=1, fsr=4'b1011, ssr=40'h00000000A5, held stable >2 cycles (defaults, no parity):
  - fsr_load pulse, then data 1,1,0,1.
  - ssr_load pulse, then 40 bits starting 1,0,1,0,0,1,0,1, then remaining zeros.
  - GAP; total frame length 47 cycles.
- Continuous enable: frames 2-4 are 6 cycles each with no ssr_load; frame 5 carries SSR again. ssr_load period = 47+3*6 = 65 cycles.
- Change fsr 4'h0 -> 4'hF during FSR_SHIFT -> current frame shifts 0000; next frame shifts 1111. Change arriving less than 2 cycles before FSR_LOAD -> old value is captured.
- Drop enable during SSR_SHIFT -> remaining SSR bits and GAP complete, busy falls after GAP, data stays 0. Re-enable -> next frame is FSR-only (counter = 1).
- Assert reset at cycle 20 of an SSR frame -> all outputs 0 immediately. After release, first frame includes SSR.
- With C3AIBADAPT_HIP_CAPTURE_PARITY_EN, fsr=4'b0111, ssr=40'h1 -> FSR parity bit 1, SSR parity bit 1, SSR frame length 49 cycles.

Source files
------------

// File: rtl/c3aibadapt_hip_async_capture_if.sv
// ---------------------------------------------------------------------------
// c3aibadapt_hip_async_capture_if
// Bundles the HIP async status inputs and the serialized sideband outputs of
// the HIP async capture block.
//   hip_aib_async_fsr_out / hip_aib_async_ssr_out : async HIP status levels
//   rx_async_hssi_fabric_fsr_load / _ssr_load     : one-cycle frame strobes
//   rx_async_sr_data                              : serial data, LSB first
//   rx_async_sr_busy                              : frame in progress
//   hip_fsr/ssr_parity_checker_out                : snapshot taps
// Modports: slave = capture block, master = HIP/fabric side (or testbench).
// ---------------------------------------------------------------------------
interface c3aibadapt_hip_async_capture_if #(
  parameter int FSR_WIDTH = 4,
  parameter int SSR_WIDTH = 40
);
  logic [FSR_WIDTH-1:0] hip_aib_async_fsr_out;
  logic [SSR_WIDTH-1:0] hip_aib_async_ssr_out;
  logic                 rx_async_hssi_fabric_fsr_load;
  logic                 rx_async_hssi_fabric_ssr_load;
  logic                 rx_async_sr_data;
  logic                 rx_async_sr_busy;
  logic                 hip_fsr_parity_checker_out;
  logic [4:0]           hip_ssr_parity_checker_out;

  modport slave (
    input  hip_aib_async_fsr_out,
    input  hip_aib_async_ssr_out,
    output rx_async_hssi_fabric_fsr_load,
    output rx_async_hssi_fabric_ssr_load,
    output rx_async_sr_data,
    output rx_async_sr_busy,
    output hip_fsr_parity_checker_out,
    output hip_ssr_parity_checker_out
  );

  modport master (
    output hip_aib_async_fsr_out,
    output hip_aib_async_ssr_out,
    input  rx_async_hssi_fabric_fsr_load,
    input  rx_async_hssi_fabric_ssr_load,
    input  rx_async_sr_data,
    input  rx_async_sr_busy,
    input  hip_fsr_parity_checker_out,
    input  hip_ssr_parity_checker_out
  );
endinterface

// File: rtl/c3aibadapt_hip_async_capture.sv
// ---------------------------------------------------------------------------
// c3aibadapt_hip_async_capture
// Synchronizes the HIP async fast/slow status bits into the oscillator clock
// domain, snapshots them at frame start and serializes them onto the async
// sideband chain. Every frame carries the FSR bits; every SSR_DIV-th frame
// also carries the SSR bits.
//
// Frame: FSR_LOAD, FSR_SHIFT x FSR_WIDTH, [SSR_LOAD, SSR_SHIFT x SSR_WIDTH], GAP
//
// Ports:
//   rx_clock_async_tx_osc_clk        oscillator clock (single domain)
//   rx_reset_async_tx_osc_clk_rst_n  async active-low reset
//   r_rx_async_sr_enable             static config, 1 = frames run continuously
//   sr_if (slave)                    status inputs and sideband outputs
//
// Optional feature macro: C3AIBADAPT_HIP_CAPTURE_PARITY_EN
//   When defined, an even-parity bit follows the last bit of each shifted
//   segment, so each SHIFT state lasts WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module c3aibadapt_hip_async_capture #(
  parameter int FSR_WIDTH = 4,
  parameter int SSR_WIDTH = 40,
  parameter int SSR_DIV   = 4
) (
  input  logic rx_clock_async_tx_osc_clk,
  input  logic rx_reset_async_tx_osc_clk_rst_n,
  input  logic r_rx_async_sr_enable,
  c3aibadapt_hip_async_capture_if.slave sr_if
);

`ifdef C3AIBADAPT_HIP_CAPTURE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int FSR_LEN = FSR_WIDTH + PAR_BITS;
  localparam int SSR_LEN = SSR_WIDTH + PAR_BITS;
  localparam int CNT_W   = $clog2(SSR_LEN + 1);
  localparam int DIV_W   = (SSR_DIV > 1) ? $clog2(SSR_DIV) : 1;

  localparam logic [CNT_W-1:0] FSR_LAST = CNT_W'(FSR_LEN - 1);
  localparam logic [CNT_W-1:0] SSR_LAST = CNT_W'(SSR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SSR_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(1'b0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FSR_LOAD  = 3'd1,
    FSR_SHIFT = 3'd2,
    SSR_LOAD  = 3'd3,
    SSR_SHIFT = 3'd4,
    GAP       = 3'd5
  } state_t;

`ifdef C3AIBADAPT_HIP_CAPTURE_PARITY_EN
  function automatic logic fsr_even_parity(input logic [FSR_WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic ssr_even_parity(input logic [SSR_WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  // Synchronizer stages
  logic [FSR_WIDTH-1:0] fsr_meta_r, fsr_sync_r;
  logic [SSR_WIDTH-1:0] ssr_meta_r, ssr_sync_r;

  // FSM state and datapath
  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     idx_r, idx_nxt_s;
  logic [DIV_W-1:0]     fcnt_r, fcnt_nxt_s;
  logic                 ssr_due_r, ssr_due_nxt_s;
  logic [FSR_WIDTH-1:0] fsr_snap_r, fsr_snap_nxt_s;
  logic [SSR_WIDTH-1:0] ssr_snap_r, ssr_snap_nxt_s;

  // Registered outputs, computed from the next state so they line up with it
  logic fsr_load_r, fsr_load_nxt_s;
  logic ssr_load_r, ssr_load_nxt_s;
  logic data_r, data_nxt_s;
  logic busy_r, busy_nxt_s;

  // Two-flop bitwise synchronizers for the quasi-static HIP status levels
  always_ff @(posedge rx_clock_async_tx_osc_clk or negedge rx_reset_async_tx_osc_clk_rst_n) begin
    if (!rx_reset_async_tx_osc_clk_rst_n) begin
      fsr_meta_r <= {FSR_WIDTH{1'b0}};
      fsr_sync_r <= {FSR_WIDTH{1'b0}};
      ssr_meta_r <= {SSR_WIDTH{1'b0}};
      ssr_sync_r <= {SSR_WIDTH{1'b0}};
    end else begin
      fsr_meta_r <= sr_if.hip_aib_async_fsr_out;
      fsr_sync_r <= fsr_meta_r;
      ssr_meta_r <= sr_if.hip_aib_async_ssr_out;
      ssr_sync_r <= ssr_meta_r;
    end
  end

  // Next-state, datapath and next-output decode of the framing FSM
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    fcnt_nxt_s     = fcnt_r;
    ssr_due_nxt_s  = ssr_due_r;
    fsr_snap_nxt_s = fsr_snap_r;
    ssr_snap_nxt_s = ssr_snap_r;
    fsr_load_nxt_s = 1'b0;
    ssr_load_nxt_s = 1'b0;
    data_nxt_s     = 1'b0;
    busy_nxt_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (r_rx_async_sr_enable) begin
          state_nxt_s = FSR_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FSR_LOAD: begin
        // Snapshot here so input motion during shifting never reaches the frame
        fsr_snap_nxt_s = fsr_sync_r;
        ssr_due_nxt_s  = (fcnt_r == DIV_ZERO);
        if (fcnt_r == DIV_ZERO) begin
          ssr_snap_nxt_s = ssr_sync_r;
        end else begin
          ssr_snap_nxt_s = ssr_snap_r;
        end
        idx_nxt_s   = CNT_ZERO;
        state_nxt_s = FSR_SHIFT;
      end
      FSR_SHIFT: begin
        if (idx_r == FSR_LAST) begin
          idx_nxt_s = CNT_ZERO;
          if (ssr_due_r) begin
            state_nxt_s = SSR_LOAD;
          end else begin
            state_nxt_s = GAP;
          end
        end else begin
          idx_nxt_s = idx_r + CNT_ONE;
        end
      end
      SSR_LOAD: begin
        idx_nxt_s   = CNT_ZERO;
        state_nxt_s = SSR_SHIFT;
      end
      SSR_SHIFT: begin
        if (idx_r == SSR_LAST) begin
          idx_nxt_s   = CNT_ZERO;
          state_nxt_s = GAP;
        end else begin
          idx_nxt_s = idx_r + CNT_ONE;
        end
      end
      GAP: begin
        // The counter survives enable drops so SSR cadence is kept on re-enable
        if (fcnt_r == DIV_LAST) begin
          fcnt_nxt_s = DIV_ZERO;
        end else begin
          fcnt_nxt_s = fcnt_r + DIV_ONE;
        end
        if (r_rx_async_sr_enable) begin
          state_nxt_s = FSR_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Output decode of the state about to be entered
    fsr_load_nxt_s = (state_nxt_s == FSR_LOAD);
    ssr_load_nxt_s = (state_nxt_s == SSR_LOAD);
    busy_nxt_s     = (state_nxt_s != IDLE);
    case (state_nxt_s)
      FSR_SHIFT: begin
        for (int i = 0; i < FSR_WIDTH; i++) begin
          if (idx_nxt_s == CNT_W'(i)) begin
            data_nxt_s = fsr_snap_nxt_s[i];
          end else begin
            data_nxt_s = data_nxt_s;
          end
        end
`ifdef C3AIBADAPT_HIP_CAPTURE_PARITY_EN
        if (idx_nxt_s == CNT_W'(FSR_WIDTH)) begin
          data_nxt_s = fsr_even_parity(fsr_snap_nxt_s);
        end else begin
          data_nxt_s = data_nxt_s;
        end
`endif
      end
      SSR_SHIFT: begin
        for (int i = 0; i < SSR_WIDTH; i++) begin
          if (idx_nxt_s == CNT_W'(i)) begin
            data_nxt_s = ssr_snap_nxt_s[i];
          end else begin
            data_nxt_s = data_nxt_s;
          end
        end
`ifdef C3AIBADAPT_HIP_CAPTURE_PARITY_EN
        if (idx_nxt_s == CNT_W'(SSR_WIDTH)) begin
          data_nxt_s = ssr_even_parity(ssr_snap_nxt_s);
        end else begin
          data_nxt_s = data_nxt_s;
        end
`endif
      end
      default: begin
        data_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, datapath and output registers
  always_ff @(posedge rx_clock_async_tx_osc_clk or negedge rx_reset_async_tx_osc_clk_rst_n) begin
    if (!rx_reset_async_tx_osc_clk_rst_n) begin
      state_r    <= IDLE;
      idx_r      <= CNT_ZERO;
      fcnt_r     <= DIV_ZERO;
      ssr_due_r  <= 1'b0;
      fsr_snap_r <= {FSR_WIDTH{1'b0}};
      ssr_snap_r <= {SSR_WIDTH{1'b0}};
      fsr_load_r <= 1'b0;
      ssr_load_r <= 1'b0;
      data_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      fcnt_r     <= fcnt_nxt_s;
      ssr_due_r  <= ssr_due_nxt_s;
      fsr_snap_r <= fsr_snap_nxt_s;
      ssr_snap_r <= ssr_snap_nxt_s;
      fsr_load_r <= fsr_load_nxt_s;
      ssr_load_r <= ssr_load_nxt_s;
      data_r     <= data_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign sr_if.rx_async_hssi_fabric_fsr_load = fsr_load_r;
  assign sr_if.rx_async_hssi_fabric_ssr_load = ssr_load_r;
  assign sr_if.rx_async_sr_data              = data_r;
  assign sr_if.rx_async_sr_busy              = busy_r;
  // Parity checker taps come straight from the snapshot registers
  assign sr_if.hip_fsr_parity_checker_out    = fsr_snap_r[0];
  assign sr_if.hip_ssr_parity_checker_out    = ssr_snap_r[4:0];

endmodule

// File: tb/tb_c3aibadapt_hip_async_capture.sv
// ---------------------------------------------------------------------------
// tb_c3aibadapt_hip_async_capture
// Directed bench for c3aibadapt_hip_async_capture with default parameters.
// Frames are captured cycle by cycle from the fsr_load sample until the next
// fsr_load or busy falling; data/strobe traces are compared with hand-built
// expected vectors. Frame bit k of a trace is the value sampled k cycles
// after the fsr_load cycle.
// ---------------------------------------------------------------------------
module tb_c3aibadapt_hip_async_capture;
  localparam int FW = 4;
  localparam int SW = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] dat, flm, slm;
  int           len, ovl, tot;

  c3aibadapt_hip_async_capture_if #(.FSR_WIDTH(FW), .SSR_WIDTH(SW)) sr_if ();

  c3aibadapt_hip_async_capture #(.FSR_WIDTH(FW), .SSR_WIDTH(SW), .SSR_DIV(4)) dut (
    .rx_clock_async_tx_osc_clk       (clk),
    .rx_reset_async_tx_osc_clk_rst_n (rst_n),
    .r_rx_async_sr_enable            (en),
    .sr_if                           (sr_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_fsr_load"}, 128'(sr_if.rx_async_hssi_fabric_fsr_load), 128'(1'b0));
    chk({tag, "_ssr_load"}, 128'(sr_if.rx_async_hssi_fabric_ssr_load), 128'(1'b0));
    chk({tag, "_data"},     128'(sr_if.rx_async_sr_data), 128'(1'b0));
    chk({tag, "_busy"},     128'(sr_if.rx_async_sr_busy), 128'(1'b0));
    chk({tag, "_fpar"},     128'(sr_if.hip_fsr_parity_checker_out), 128'(1'b0));
    chk({tag, "_spar"},     128'(sr_if.hip_ssr_parity_checker_out), 128'(5'b0));
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!sr_if.rx_async_hssi_fabric_fsr_load && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(sr_if.rx_async_hssi_fabric_fsr_load), 128'(1'b1));
  endtask

  // Records one frame; optional fsr change / enable drop at frame cycle k
  task automatic capture(input int chg_at, input logic [3:0] chg_fsr, input int en_off_at);
    int k;
    k = 0; dat = '0; flm = '0; slm = '0; ovl = 0;
    do begin
      dat[k] = sr_if.rx_async_sr_data;
      flm[k] = sr_if.rx_async_hssi_fabric_fsr_load;
      slm[k] = sr_if.rx_async_hssi_fabric_ssr_load;
      if (sr_if.rx_async_hssi_fabric_fsr_load && sr_if.rx_async_hssi_fabric_ssr_load) ovl++;
      if (!sr_if.rx_async_sr_busy) ovl++;
      if (k == chg_at) sr_if.hip_aib_async_fsr_out = chg_fsr;
      if (k == en_off_at) en = 1'b0;
      @(negedge clk);
      k++;
    end while (!(sr_if.rx_async_hssi_fabric_fsr_load || !sr_if.rx_async_sr_busy) && k < 127);
    len = k;
  endtask

  initial begin
    sr_if.hip_aib_async_fsr_out = 4'b1011;
    sr_if.hip_aib_async_ssr_out = 40'h00000000A5;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`ifdef C3AIBADAPT_HIP_CAPTURE_PARITY_EN
    sr_if.hip_aib_async_fsr_out = 4'b0111;
    sr_if.hip_aib_async_ssr_out = 40'h0000000001;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_load("p_start");
    capture(-1, 4'h0, -1);
    chk("p_len", 128'(len), 128'(49));
    chk("p_dat", dat, 128'h0000_0000_0000_0000_0000_8000_0000_00AE);
    chk("p_slm", slm, 128'h40);
    capture(-1, 4'h0, -1);
    chk("p_len_fsr_only", 128'(len), 128'(7));
    chk("p_dat_fsr_only", dat, 128'h2E);
`else
    en = 1'b1;
    wait_load("f1_start");
    // Frame 1: SSR frame, fsr 1011 -> 1,1,0,1; ssr A5 LSB first
    capture(-1, 4'h0, -1);
    tot = len;
    chk("f1_len", 128'(len), 128'(47));
    chk("f1_dat", dat, 128'h0000_0000_0000_0000_0000_0000_0000_2956);
    chk("f1_ssr_first8", 128'(dat[13:6]), 128'(8'hA5));
    chk("f1_flm", flm, 128'h1);
    chk("f1_slm", slm, 128'h20);
    chk("f1_overlap", 128'(ovl), 128'(0));
    chk("f1_fpar", 128'(sr_if.hip_fsr_parity_checker_out), 128'(1'b1));
    chk("f1_spar", 128'(sr_if.hip_ssr_parity_checker_out), 128'(5'b00101));
    // Frames 2-4: FSR-only
    for (int f = 2; f <= 4; f++) begin
      capture(-1, 4'h0, -1);
      tot += len;
      chk($sformatf("f%0d_len", f), 128'(len), 128'(6));
      chk($sformatf("f%0d_dat", f), dat, 128'h16);
      chk($sformatf("f%0d_slm", f), slm, 128'h0);
    end
    chk("ssr_period", 128'(tot), 128'(65));
    // Change arriving at FSR_LOAD is too late: frame 5 still shifts 1011
    sr_if.hip_aib_async_fsr_out = 4'h0;
    capture(-1, 4'h0, -1);
    chk("f5_len", 128'(len), 128'(47));
    chk("f5_dat", dat, 128'h2956);
    chk("f5_slm", slm, 128'h20);
    // Frame 6 shifts 0000; fsr goes to F mid-shift
    capture(2, 4'hF, -1);
    chk("f6_len", 128'(len), 128'(6));
    chk("f6_dat", dat, 128'h0);
    chk("f6_fpar", 128'(sr_if.hip_fsr_parity_checker_out), 128'(1'b0));
    capture(-1, 4'h0, -1);
    chk("f7_dat", dat, 128'h1E);
    chk("f7_fpar", 128'(sr_if.hip_fsr_parity_checker_out), 128'(1'b1));
    capture(-1, 4'h0, -1);
    chk("f8_len", 128'(len), 128'(6));
    // Frame 9: SSR frame; enable drops during SSR_SHIFT, frame still completes
    capture(-1, 4'h0, 20);
    chk("f9_len", 128'(len), 128'(47));
    chk("f9_dat", dat, 128'h295E);
    chk("f9_slm", slm, 128'h20);
    chk("f9_overlap", 128'(ovl), 128'(0));
    repeat (3) @(negedge clk);
    chk("idle_busy", 128'(sr_if.rx_async_sr_busy), 128'(1'b0));
    chk("idle_data", 128'(sr_if.rx_async_sr_data), 128'(1'b0));
    chk("idle_fsr_load", 128'(sr_if.rx_async_hssi_fabric_fsr_load), 128'(1'b0));
    // Re-enable: counter retained at 1, so FSR-only
    en = 1'b1;
    wait_load("reen_start");
    capture(-1, 4'h0, -1);
    chk("reen_len", 128'(len), 128'(6));
    chk("reen_slm", slm, 128'h0);
    capture(-1, 4'h0, -1);
    capture(-1, 4'h0, -1);
    chk("pre_ssr_len", 128'(len), 128'(6));
    // Now at FSR_LOAD of an SSR frame; reset at frame cycle 20
    repeat (20) @(negedge clk);
    chk("mid_busy", 128'(sr_if.rx_async_sr_busy), 128'(1'b1));
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_quiet("mid_reset");
    sr_if.hip_aib_async_ssr_out = 40'h8000000001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_load("post_rst_start");
    capture(-1, 4'h0, -1);
    chk("post_rst_len", 128'(len), 128'(47));
    chk("post_rst_slm", slm, 128'h20);
    chk("post_rst_dat", dat, 128'h0000_0000_0000_0000_0000_2000_0000_005E);
    chk("post_rst_spar", 128'(sr_if.hip_ssr_parity_checker_out), 128'(5'b00001));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
